ballot_terminal: RTL and testbench

BALLOT_TERMINAL -- requirements
Module: ballot_terminal

---
 rtl/ballot_terminal.sv | 219 +++++++++++++++++++++
 tb/tb_ballot_terminal.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ballot_terminal.sv
// rtl/ballot_terminal.sv - voter request queue, election issue FSM and phase timer (optional LOCAL_PHASE_CHECK_EN)
module ballot_terminal (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_mode,
    input  logic [5:0] req_userID,
    input  logic [1:0] req_candidate,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic [5:0] resp_userID,
    output logic [2:0] resp_code,
    output logic       elec_valid,
    output logic [1:0] mode,
    output logic [5:0] userID,
    output logic [1:0] candidate,
    input  logic       AlreadyRegistered,
    input  logic       AlreadyVoted,
    input  logic       NotRegistered,
    input  logic       VotingHasNotStarted,
    input  logic       RegistrationHasEnded,
    output logic [1:0] phase
);

    localparam logic [7:0] COUNT_MAX = 8'd201;
    localparam logic [1:0] PH_REG    = 2'd0;
    localparam logic [1:0] PH_VOTE   = 2'd1;
    localparam logic [1:0] PH_CLOSED = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t      state_q;
    logic [7:0]  count_q, count_d;
    logic [9:0]  fifo_q [4];
    logic [1:0]  wr_ptr_q, rd_ptr_q;
    logic [2:0]  occ_q, occ_d;
    logic        push, pop;
    logic [9:0]  head;
    logic [1:0]  head_mode;
    logic [5:0]  head_id;
    logic [1:0]  head_cand;
    logic [5:0]  hold_id_q;
    logic [2:0]  status_code;

    logic        resp_valid_q;
    logic [5:0]  resp_userID_q;
    logic [2:0]  resp_code_q;
    logic        elec_valid_q;
    logic [1:0]  mode_q;
    logic [5:0]  userID_q;
    logic [1:0]  candidate_q;

    // Saturating cycle counter drives the election phase
    always_comb begin
        count_d = count_q;
        if (count_q != COUNT_MAX) begin
            count_d = count_q + 8'd1;
        end
    end

    // Counter register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Phase decode from the counter
    always_comb begin
        phase = PH_CLOSED;
        if (count_q <= 8'd100) begin
            phase = PH_REG;
        end else if (count_q <= 8'd200) begin
            phase = PH_VOTE;
        end
    end

    // Ready depends only on registered occupancy, so a pop never frees a slot combinationally
    assign req_ready = (occ_q != 3'd4);
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == S_IDLE) && (occ_q != 3'd0);
    assign head      = fifo_q[rd_ptr_q];
    assign head_mode = head[9:8];
    assign head_id   = head[7:2];
    assign head_cand = head[1:0];

    // Occupancy next state: simultaneous push and pop leave it unchanged
    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 3'd1;
        end else if (pop && !push) begin
            occ_d = occ_q - 3'd1;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {req_mode, req_userID, req_candidate};
        end
    end

    // FIFO pointers wrap naturally at 4 entries
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            occ_q    <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            occ_q <= occ_d;
        end
    end

    // Status-to-code priority, most specific rejection first
    always_comb begin
        status_code = 3'd0;
        if (AlreadyRegistered) begin
            status_code = 3'd1;
        end else if (AlreadyVoted) begin
            status_code = 3'd2;
        end else if (NotRegistered) begin
            status_code = 3'd3;
        end else if (VotingHasNotStarted) begin
            status_code = 3'd4;
        end else if (RegistrationHasEnded) begin
            status_code = 3'd5;
        end
    end

    // Request sequencer: pop, issue to the election block, collect status, hand back a result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= S_IDLE;
            hold_id_q     <= 6'd0;
            resp_valid_q  <= 1'b0;
            resp_userID_q <= 6'd0;
            resp_code_q   <= 3'd0;
            elec_valid_q  <= 1'b0;
            mode_q        <= 2'd0;
            userID_q      <= 6'd0;
            candidate_q   <= 2'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        hold_id_q <= head_id;
                        if (phase == PH_CLOSED) begin
                            resp_code_q   <= 3'd6;
                            resp_userID_q <= head_id;
                            resp_valid_q  <= 1'b1;
                            state_q       <= S_RESP;
`ifdef LOCAL_PHASE_CHECK_EN
                        end else if ((head_mode == 2'd1) && (phase == PH_REG)) begin
                            resp_code_q   <= 3'd4;
                            resp_userID_q <= head_id;
                            resp_valid_q  <= 1'b1;
                            state_q       <= S_RESP;
                        end else if ((head_mode == 2'd0) && (phase == PH_VOTE)) begin
                            resp_code_q   <= 3'd5;
                            resp_userID_q <= head_id;
                            resp_valid_q  <= 1'b1;
                            state_q       <= S_RESP;
`endif
                        end else begin
                            elec_valid_q <= 1'b1;
                            mode_q       <= head_mode;
                            userID_q     <= head_id;
                            candidate_q  <= head_cand;
                            state_q      <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    elec_valid_q <= 1'b0;
                    state_q      <= S_WAIT;
                end
                S_WAIT: begin
                    resp_code_q   <= status_code;
                    resp_userID_q <= hold_id_q;
                    resp_valid_q  <= 1'b1;
                    state_q       <= S_RESP;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_userID = resp_userID_q;
    assign resp_code   = resp_code_q;
    assign elec_valid  = elec_valid_q;
    assign mode        = mode_q;
    assign userID      = userID_q;
    assign candidate   = candidate_q;

endmodule

// File: tb/tb_ballot_terminal.sv
// tb/tb_ballot_terminal.sv - scoreboard bench for ballot_terminal
module tb_ballot_terminal;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_mode = 2'd0;
    logic [5:0] req_userID = 6'd0;
    logic [1:0] req_candidate = 2'd0;
    logic       resp_valid;
    logic       resp_ready = 1'b1;
    logic [5:0] resp_userID;
    logic [2:0] resp_code;
    logic       elec_valid;
    logic [1:0] mode;
    logic [5:0] userID;
    logic [1:0] candidate;
    logic       st_ar = 1'b0, st_av = 1'b0, st_nr = 1'b0, st_vhns = 1'b0, st_rhe = 1'b0;
    logic [1:0] phase;

`ifdef LOCAL_PHASE_CHECK_EN
    localparam bit PC = 1'b1;
`else
    localparam bit PC = 1'b0;
`endif

    typedef struct {
        logic [5:0] id;
        logic [2:0] code;
    } resp_t;

    typedef struct {
        logic [1:0] m;
        logic [5:0] id;
        logic [1:0] c;
    } elec_t;

    resp_t resp_q[$];
    elec_t elec_q[$];
    resp_t mon_r;
    elec_t mon_e;
    int    n_cmp = 0;
    int    n_fail = 0;

    ballot_terminal dut (
        .CLK                  (CLK),
        .RST_N                (RST_N),
        .req_valid            (req_valid),
        .req_ready            (req_ready),
        .req_mode             (req_mode),
        .req_userID           (req_userID),
        .req_candidate        (req_candidate),
        .resp_valid           (resp_valid),
        .resp_ready           (resp_ready),
        .resp_userID          (resp_userID),
        .resp_code            (resp_code),
        .elec_valid           (elec_valid),
        .mode                 (mode),
        .userID               (userID),
        .candidate            (candidate),
        .AlreadyRegistered    (st_ar),
        .AlreadyVoted         (st_av),
        .NotRegistered        (st_nr),
        .VotingHasNotStarted  (st_vhns),
        .RegistrationHasEnded (st_rhe),
        .phase                (phase)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Response monitor: every completed handshake must match the oldest expectation
    always @(negedge CLK) begin
        if (RST_N && resp_valid && resp_ready) begin
            if (resp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got id %0d code %0d, expected none", resp_userID, resp_code);
            end else begin
                mon_r = resp_q.pop_front();
                chk("resp_userID", int'(resp_userID), int'(mon_r.id));
                chk("resp_code", int'(resp_code), int'(mon_r.code));
            end
        end
    end

    // Election-side monitor: each issue pulse must match the oldest expected issue
    always @(negedge CLK) begin
        if (RST_N && elec_valid) begin
            if (elec_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_elec: got id %0d mode %0d, expected none", userID, mode);
            end else begin
                mon_e = elec_q.pop_front();
                chk("elec_mode", int'(mode), int'(mon_e.m));
                chk("elec_userID", int'(userID), int'(mon_e.id));
                chk("elec_candidate", int'(candidate), int'(mon_e.c));
            end
        end
    end

    task automatic push(input logic [1:0] m, input logic [5:0] id, input logic [1:0] c,
                        input logic [2:0] code, input bit issue);
        int    n;
        resp_t r;
        elec_t e;
        r.id   = id;
        r.code = code;
        resp_q.push_back(r);
        if (issue) begin
            e.m  = m;
            e.id = id;
            e.c  = c;
            elec_q.push_back(e);
        end
        req_valid     = 1'b1;
        req_mode      = m;
        req_userID    = id;
        req_candidate = c;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!req_ready) begin
            chk("push_timeout", 0, 1);
        end
        @(negedge CLK);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((resp_q.size() != 0 || resp_valid) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("drain_resp", resp_q.size(), 0);
        chk("drain_elec", elec_q.size(), 0);
    endtask

    task automatic wait_phase(input logic [1:0] p);
        int n;
        n = 0;
        while (phase != p && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("phase_reach", int'(phase), int'(p));
    endtask

    task automatic set_st(input logic [4:0] s);
        {st_ar, st_av, st_nr, st_vhns, st_rhe} = s;
    endtask

    logic [4:0] pri_st   [6] = '{5'b10100, 5'b01100, 5'b00110, 5'b00011, 5'b00001, 5'b11111};
    logic [2:0] pri_code [6] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};

    initial begin
        int n;
        repeat (2) @(negedge CLK);
        chk("rst_req_ready", int'(req_ready), 1);
        chk("rst_resp_valid", int'(resp_valid), 0);
        chk("rst_elec_valid", int'(elec_valid), 0);
        chk("rst_resp_code", int'(resp_code), 0);
        chk("rst_resp_userID", int'(resp_userID), 0);
        chk("rst_mode", int'(mode), 0);
        chk("rst_userID", int'(userID), 0);
        chk("rst_candidate", int'(candidate), 0);
        chk("rst_phase", int'(phase), 0);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Register ID 5: issue one edge after pop, response three edges after pop
        push(2'd0, 6'd5, 2'd0, 3'd0, 1'b1);
        @(negedge CLK);
        chk("t1_elec_valid", int'(elec_valid), 1);
        chk("t1_elec_userID", int'(userID), 5);
        @(negedge CLK);
        chk("t1_elec_drop", int'(elec_valid), 0);
        chk("t1_resp_early", int'(resp_valid), 0);
        @(negedge CLK);
        chk("t1_resp_valid", int'(resp_valid), 1);
        chk("t1_resp_code", int'(resp_code), 0);
        drain();

        // Vote during REG phase
        push(2'd1, 6'd20, 2'd2, PC ? 3'd4 : 3'd0, !PC);
        drain();

        // Back-pressure: FSM parked in RESP, queue fills after four pushes
        resp_ready = 1'b0;
        push(2'd0, 6'd30, 2'd0, 3'd0, 1'b1);
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("bp_first_resp", int'(resp_valid), 1);
        for (int i = 0; i < 4; i++) begin
            push(2'd0, 6'(31 + i), 2'(i), 3'd0, 1'b1);
        end
        chk("bp_full_ready", int'(req_ready), 0);
        fork
            begin
                repeat (4) @(negedge CLK);
                chk("bp_held_ready", int'(req_ready), 0);
                resp_ready = 1'b1;
            end
            push(2'd0, 6'd35, 2'd3, 3'd0, 1'b1);
        join
        drain();

        // Status priority during VOTE phase
        wait_phase(2'd1);
        for (int i = 0; i < 6; i++) begin
            set_st(pri_st[i]);
            push(2'd1, 6'(40 + i), 2'(i), pri_code[i], 1'b1);
            drain();
        end
        set_st(5'b00000);

        // Register during VOTE phase
        push(2'd0, 6'd50, 2'd1, PC ? 3'd5 : 3'd0, !PC);
        drain();

        // CLOSED: code 6 after one edge, never issued
        wait_phase(2'd2);
        push(2'd1, 6'd55, 2'd3, 3'd6, 1'b0);
        @(negedge CLK);
        chk("closed_resp_valid", int'(resp_valid), 1);
        chk("closed_resp_code", int'(resp_code), 6);
        chk("closed_elec_valid", int'(elec_valid), 0);
        chk("closed_phase", int'(phase), 2);
        drain();

        // Reset mid-operation while in WAIT with two entries queued
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        push(2'd0, 6'd60, 2'd0, 3'd0, 1'b1);
        push(2'd0, 6'd61, 2'd1, 3'd0, 1'b0);
        push(2'd0, 6'd62, 2'd2, 3'd0, 1'b0);
        resp_q.delete();
        elec_q.delete();
        RST_N = 1'b0;
        #1;
        chk("mid_rst_resp_valid", int'(resp_valid), 0);
        chk("mid_rst_req_ready", int'(req_ready), 1);
        chk("mid_rst_count", int'(dut.count_q), 0);
        chk("mid_rst_phase", int'(phase), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        repeat (10) @(negedge CLK);
        chk("post_rst_resp_valid", int'(resp_valid), 0);
        push(2'd0, 6'd63, 2'd1, 3'd0, 1'b1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
